// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

  localparam int DIV_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_paso.sv
// rtl/div_paso.sv - one restoring shift-subtract step of the divider
module div_paso #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;

  // The shifted remainder needs one extra bit before the compare; it always fits back in WIDTH afterwards.
  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {1'b0, div_i});
    rem_o   = q_o ? WIDTH'(shifted - {1'b0, div_i}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential signed/unsigned restoring divider with valid/ready handshakes
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  input  logic             con_signo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] resto,
  output logic             div_cero,
  output logic             desborde
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] cociente_q, cociente_d;
  logic [WIDTH-1:0] resto_q, resto_d;
  logic             div_cero_q, div_cero_d;
  logic             desborde_q, desborde_d;

  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] quo_nxt;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic signed_mode);
    return (signed_mode && v[WIDTH-1]) ? -v : v;
  endfunction

  div_paso #(.WIDTH(WIDTH)) u_paso (
    .rem_i (rem_q),
    .bit_i (a_q[WIDTH-1]),
    .div_i (b_q),
    .rem_o (rem_nxt),
    .q_o   (q_bit)
  );

  // Quotient bits shift into the dividend register as its bits are consumed.
  assign quo_nxt = {a_q[WIDTH-2:0], q_bit};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
    cociente_d = cociente_q;
    resto_d    = resto_q;
    div_cero_d = div_cero_q;
    desborde_d = desborde_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dz_d    = (divisor == '0);
          ovf_d   = con_signo && (dividendo == MOST_NEG) && (divisor == '1);
          a_d     = (divisor == '0) ? dividendo : mag(dividendo, con_signo);
          b_d     = mag(divisor, con_signo);
          rem_d   = '0;
          cnt_d   = '0;
          negq_d  = con_signo && (dividendo[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d  = con_signo && dividendo[WIDTH-1];
          state_d = CALC;
        end
      end
      CALC: begin
        // A zero divisor spends a single cycle here so its result appears one edge after acceptance.
        if (dz_q) begin
          cociente_d = '1;
          resto_d    = a_q;
          div_cero_d = 1'b1;
          desborde_d = 1'b0;
          state_d    = DONE;
        end else begin
          a_d   = quo_nxt;
          rem_d = rem_nxt;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            cociente_d = negq_q ? -quo_nxt : quo_nxt;
            resto_d    = negr_q ? -rem_nxt : rem_nxt;
            div_cero_d = 1'b0;
            desborde_d = ovf_q;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      cociente_q <= '0;
      resto_q    <= '0;
      div_cero_q <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
      cociente_q <= cociente_d;
      resto_q    <= resto_d;
      div_cero_q <= div_cero_d;
      desborde_q <= desborde_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign cociente  = cociente_q;
  assign resto     = resto_q;
  assign div_cero  = div_cero_q;
  assign desborde  = desborde_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq at WIDTH=4
module tb_div_seq;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] dividendo = '0;
  logic [3:0] divisor = '0;
  logic       con_signo = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] cociente;
  logic [3:0] resto;
  logic       div_cero;
  logic       desborde;

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  div_seq #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividendo (dividendo),
    .divisor   (divisor),
    .con_signo (con_signo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cociente  (cociente),
    .resto     (resto),
    .div_cero  (div_cero),
    .desborde  (desborde)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic s);
    exp_t m;
    int   sa, sb_, q, r;
    m.dz = 1'b0;
    m.ov = 1'b0;
    if (b == 4'd0) begin
      q    = 15;
      r    = int'(a);
      m.dz = 1'b1;
    end else if (s) begin
      sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
      sb_ = (b >= 4'd8) ? int'(b) - 16 : int'(b);
      if (sa == -8 && sb_ == -1) begin
        q    = -8;
        r    = 0;
        m.ov = 1'b1;
      end else begin
        q = sa / sb_;
        r = sa % sb_;
      end
    end else begin
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
    end
    m.q = q[3:0];
    m.r = r[3:0];
    return m;
  endfunction

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic s, input int hold);
    int    n;
    int    lat;
    exp_t  e;
    string t;
    t = $sformatf("%0d/%0d s%0d", a, b, s);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({t, " in_ready_wait"}, in_ready, 1);
    dividendo = a;
    divisor   = b;
    con_signo = s;
    in_valid  = 1'b1;
    sb.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dividendo = 4'($urandom);
    divisor   = 4'($urandom);
    con_signo = 1'($urandom);
    check_eq({t, " busy_in_ready"}, in_ready, 0);
    check_eq({t, " busy_out_valid"}, out_valid, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({t, " latency"}, lat, (b == 4'd0) ? 1 : 4);
    if (sb.size() == 0) begin
      check_eq({t, " sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check_eq({t, " cociente"}, cociente, e.q);
      check_eq({t, " resto"}, resto, e.r);
      check_eq({t, " div_cero"}, div_cero, e.dz);
      check_eq({t, " desborde"}, desborde, e.ov);
      if (b != 4'd0)
        check_eq({t, " identity"}, (int'(cociente) * int'(b) + int'(resto)) & 15, a);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check_eq({t, " hold_valid"}, out_valid, 1);
        check_eq({t, " hold_in_ready"}, in_ready, 0);
        check_eq({t, " hold_cociente"}, cociente, e.q);
        check_eq({t, " hold_resto"}, resto, e.r);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({t, " consumed_valid"}, out_valid, 0);
    check_eq({t, " consumed_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst in_ready", in_ready, 1);
    check_eq("rst out_valid", out_valid, 0);
    check_eq("rst cociente", cociente, 0);
    check_eq("rst resto", resto, 0);
    check_eq("rst flags", {div_cero, desborde}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(4'd15, 4'd4, 1'b0, 0);
    run_op(4'd0, 4'd3, 1'b0, 0);
    run_op(4'b1001, 4'b0010, 1'b1, 0);
    run_op(4'd7, 4'b1110, 1'b1, 0);
    run_op(4'd5, 4'd0, 1'b0, 0);
    run_op(4'd5, 4'd0, 1'b1, 0);
    run_op(4'b1000, 4'b1111, 1'b1, 0);
    run_op(4'd12, 4'd5, 1'b0, 10);

    // abort 9/3 after two iterations
    @(negedge clk);
    dividendo = 4'd9;
    divisor   = 4'd3;
    con_signo = 1'b0;
    in_valid  = 1'b1;
    sb.push_back(model(4'd9, 4'd3, 1'b0));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("abort in_ready", in_ready, 1);
    check_eq("abort out_valid", out_valid, 0);
    check_eq("abort cociente", cociente, 0);
    check_eq("abort resto", resto, 0);
    check_eq("abort flags", {div_cero, desborde}, 0);
    sb.delete();
    #2 rst_n = 1'b1;
    run_op(4'd10, 4'd10, 1'b0, 0);

    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run_op(4'(a), 4'(b), 1'(s), $urandom_range(0, 2));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range is 2..32.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, and is the reset; it is asynchronous and active-low.
REQ-004 Port in_valid SHALL be an input, 1 bit wide, indicating that an operation request is present.
REQ-005 Port in_ready SHALL be an output, 1 bit wide, indicating that the block can accept a request.
REQ-006 Port dividendo SHALL be an input, WIDTH bits wide, carrying the dividend.
REQ-007 Port divisor SHALL be an input, WIDTH bits wide, carrying the divisor.
REQ-008 Port con_signo SHALL be an input, 1 bit wide: 1 selects two's-complement signed division, 0 selects unsigned.
REQ-009 Port out_valid SHALL be an output, 1 bit wide, indicating that a result is present.
REQ-010 Port out_ready SHALL be an input, 1 bit wide, indicating that the consumer accepts the result.
REQ-011 Port cociente SHALL be an output, WIDTH bits wide, carrying the quotient.
REQ-012 Port resto SHALL be an output, WIDTH bits wide, carrying the remainder.
REQ-013 Port div_cero SHALL be an output, 1 bit wide, flagging that the divisor was 0.
REQ-014 Port desborde SHALL be an output, 1 bit wide, flagging signed overflow (most-negative value divided by -1).

Function
REQ-015 The block SHALL be an FSM with states IDLE, CALC and DONE.
REQ-016 The block SHALL assert in_ready only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-018 On acceptance the block SHALL register dividendo, divisor and con_signo; later input changes are ignored until the next acceptance.
REQ-019 On acceptance with a nonzero divisor, the block SHALL store the operand magnitudes (absolute values when con_signo=1) and the result signs, then go to CALC.
REQ-020 In CALC the block SHALL perform one restoring shift-subtract iteration per cycle, WIDTH iterations in total, using an iteration counter of $clog2(WIDTH+1) bits.
REQ-021 On the last iteration the block SHALL apply sign correction, go to DONE and assert out_valid.
REQ-022 For a nonzero divisor, out_valid SHALL rise exactly WIDTH cycles after the acceptance edge.
REQ-023 In signed mode the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend, so that cociente*divisor+resto == dividendo in WIDTH-bit arithmetic.
REQ-024 When divisor==0, the block SHALL skip CALC and go to DONE on the edge after acceptance, with out_valid=1, cociente all ones, resto equal to the captured dividendo, div_cero=1 and desborde=0.
REQ-025 For signed most-negative divided by -1, the block SHALL produce cociente equal to the most-negative value, resto=0 and desborde=1, with the normal WIDTH-cycle latency.
REQ-026 In DONE, cociente, resto, div_cero and desborde SHALL stay stable until an edge where out_ready=1.
REQ-027 On that edge the block SHALL deassert out_valid and return to IDLE.
REQ-028 A new request SHALL NOT be accepted in the same cycle the result is consumed; at minimum, in_ready rises one cycle after the out handshake.
REQ-029 out_valid SHALL be 0 in IDLE and in CALC.
REQ-030 The block SHALL NOT register in_valid in CALC or DONE.

Reset
REQ-031 When rst_n=0, the block SHALL enter IDLE immediately, regardless of clk or the current state, including mid-CALC, and discard any operation in progress.
REQ-032 During reset, out_valid, cociente, resto, div_cero and desborde SHALL be 0 and in_ready SHALL be 1.
REQ-033 After rst_n deasserts, the first accepted request SHALL complete normally with no residue from an aborted operation.

Structure
REQ-034 Package div_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and the default-width constant DIV_WIDTH_DEF=8.
REQ-035 One combinational sub-module, div_paso, SHALL implement a single restoring iteration: inputs are partial remainder, next dividend bit and divisor magnitude; outputs are the new partial remainder and the quotient bit.
REQ-036 div_seq SHALL hold the FSM, the counter, the operand/sign registers and the sign correction.

Verification
REQ-037 With WIDTH=4, unsigned 15/4 -> after 4 cycles cociente=3, resto=3, flags 0; unsigned 0/3 -> cociente=0, resto=0.
REQ-038 With WIDTH=4, signed -7/2 (4'b1001/4'b0010) -> cociente=-3 (4'b1101), resto=-1 (4'b1111); signed 7/-2 -> cociente=-3, resto=1.
REQ-039 With WIDTH=4, 5/0 in either mode -> out_valid 1 cycle after acceptance, cociente=4'hF, resto=5, div_cero=1.
REQ-040 With WIDTH=4, signed -8/-1 -> cociente=4'b1000, resto=0, desborde=1.
REQ-041 With out_ready held 0 for 10 cycles after 12/5 -> outputs stay at cociente=2, resto=2 and in_ready=0 throughout; in_ready=1 one cycle after out_ready=1.
REQ-042 rst_n pulsed low at CALC iteration 2 of 9/3 -> outputs go to 0 asynchronously; a following 10/10 yields cociente=1, resto=0.
REQ-043 A random sweep over all WIDTH=4 operand pairs in both modes SHALL check cociente*divisor+resto == dividendo against a reference model.
